// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART APB scheduler and the UART register block.
//   schedState_t  - scheduler FSM states
//   UART_TX_ADDR  - default APB address of the UART TX data register
//   UART_RX_ADDR  - default APB address of the UART RX data register
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_START,
    WAIT_DONE
  } schedState_t;

  localparam logic [31:0] UART_TX_ADDR = 32'd0;
  localparam logic [31:0] UART_RX_ADDR = 32'd1;

endpackage

// File: rtl/uart_req_arbiter.sv
// uart_req_arbiter: two-requester arbiter for the UART TX path.
//   valid[1:0] - request lines from requester 0 and requester 1
//   ptr        - requester that wins when both are requesting
//   grant      - index of the winning requester (only meaningful when any valid is set)
// A constant ptr of 0 gives fixed priority; a rotating ptr gives round-robin.
module uart_req_arbiter (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (valid[0] && valid[1]) begin
      grant = ptr;
    end else if (valid[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/uart_apb_scheduler.sv
// uart_apb_scheduler: APB master that serialises UART traffic. RX reads take
// priority over TX writes; TX bytes come from two requesters through an arbiter.
// After a TX write it waits for tx_busy to rise and fall, bounded by BUSY_TIMEOUT.
//   pClk, pReset                 - clock, asynchronous active-high reset
//   reqN_valid/reqN_data/reqN_ready - TX byte handshake per requester (ready is a 1-cycle pulse)
//   rx_avail, tx_busy            - UART status levels
//   pSel/pEnable/pWrite/pAddr/pWdata/pReadData - APB master port
//   rx_data, rx_data_valid       - last RX byte read and its update pulse
//   grant_id                     - requester owning the current TX transaction
//   tx_timeout                   - pulse when the TX completion wait expires
// Build option: define UART_SCHED_RR_EN for round-robin arbitration; otherwise
// requester 0 always wins a tie.
module uart_apb_scheduler
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR,
  parameter logic [31:0] RX_ADDR      = UART_RX_ADDR,
  parameter int          BUSY_TIMEOUT = 2_000_000
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        rx_avail,
  input  logic        tx_busy,
  output logic        pSel,
  output logic        pEnable,
  output logic        pWrite,
  output logic [31:0] pAddr,
  output logic [31:0] pWdata,
  input  logic [31:0] pReadData,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        grant_id,
  output logic        tx_timeout
);

  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  schedState_t      state, stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             rrPtr;
  logic             grant;
  logic             accept;
  logic             waiting;
  logic             expire;
  logic             unusedReadHi;

  assign unusedReadHi = ^pReadData[31:8];

  uart_req_arbiter arb (
    .valid ({req1_valid, req0_valid}),
    .ptr   (rrPtr),
    .grant (grant)
  );

  // A TX grant only happens in IDLE when no RX byte is pending. Reset gates it
  // because state is already IDLE while reset is held.
  assign accept     = (state == IDLE) && !pReset && !rx_avail && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign waiting    = (state == WAIT_START) || (state == WAIT_DONE);
  assign expire     = waiting && (waitCnt == CNT_LAST);
  assign tx_timeout = expire;

  assign pSel    = (state == SETUP) || (state == ACCESS);
  assign pEnable = (state == ACCESS);

`ifdef UART_SCHED_RR_EN
  // The requester that just won loses the next tie.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      rrPtr <= 1'b0;
    end else if (accept) begin
      rrPtr <= ~grant;
    end
  end
`else
  assign rrPtr = 1'b0;
`endif

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (rx_avail || accept) begin
          stateNext = SETUP;
        end
      end
      SETUP:  stateNext = ACCESS;
      ACCESS: stateNext = pWrite ? WAIT_START : IDLE;
      // Timeout is checked first so the counter bound holds in both wait states.
      WAIT_START: begin
        if (expire) begin
          stateNext = IDLE;
        end else if (tx_busy) begin
          stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (expire || !tx_busy) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      pWrite        <= 1'b0;
      pAddr         <= '0;
      pWdata        <= '0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      grant_id      <= 1'b0;
      waitCnt       <= '0;
    end else begin
      rx_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_avail) begin
            pWrite <= 1'b0;
            pAddr  <= RX_ADDR;
          end else if (accept) begin
            pWrite   <= 1'b1;
            pAddr    <= TX_ADDR;
            pWdata   <= {24'd0, (grant ? req1_data : req0_data)};
            grant_id <= grant;
          end
        end
        ACCESS: begin
          waitCnt <= '0;
          if (!pWrite) begin
            rx_data       <= pReadData[7:0];
            rx_data_valid <= 1'b1;
          end
        end
        WAIT_START, WAIT_DONE: waitCnt <= waitCnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_scheduler.sv
// tb_uart_apb_scheduler: directed scoreboard bench for uart_apb_scheduler.
// dutA (default timeout) carries the main traffic; dutT (BUSY_TIMEOUT=50) is held
// in reset except for the timeout scenario. Expected APB accesses and RX bytes are
// queued as stimulus is issued and popped by a negedge monitor.
// Define UART_SCHED_RR_EN for both RTL and bench to check round-robin grants.
module tb_uart_apb_scheduler;
  import uart_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          gid;
  } apbExp_t;

  logic pClk = 1'b0;
  always #5 pClk = ~pClk;

  logic        pReset, rstT;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        rx_avail, tx_busy;
  logic [31:0] pReadData;

  logic        req0_ready, req1_ready, pSel, pEnable, pWrite, rx_data_valid, grant_id, tx_timeout;
  logic [31:0] pAddr, pWdata;
  logic [7:0]  rx_data;

  logic        tReq0Ready, tReq1Ready, tPSel, tPEnable, tPWrite, tRxDataValid, tGrantId, tTxTimeout;
  logic [31:0] tPAddr, tPWdata;
  logic [7:0]  tRxData;

  uart_apb_scheduler #(.TX_ADDR(32'd0), .RX_ADDR(32'd1), .BUSY_TIMEOUT(2_000_000)) dutA (
    .pClk(pClk), .pReset(pReset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rx_avail(rx_avail), .tx_busy(tx_busy),
    .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .grant_id(grant_id), .tx_timeout(tx_timeout)
  );

  uart_apb_scheduler #(.TX_ADDR(32'd0), .RX_ADDR(32'd1), .BUSY_TIMEOUT(50)) dutT (
    .pClk(pClk), .pReset(rstT),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(tReq0Ready), .req1_ready(tReq1Ready),
    .rx_avail(rx_avail), .tx_busy(tx_busy),
    .pSel(tPSel), .pEnable(tPEnable), .pWrite(tPWrite),
    .pAddr(tPAddr), .pWdata(tPWdata), .pReadData(pReadData),
    .rx_data(tRxData), .rx_data_valid(tRxDataValid),
    .grant_id(tGrantId), .tx_timeout(tTxTimeout)
  );

  int passCnt = 0;
  int totalCnt = 0;
  int rxPulses = 0;
  int aTimeouts = 0;
  apbExp_t     apbQ[$];
  logic [7:0]  rxQ[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic pushWr(input logic [7:0] d, input bit g);
    apbExp_t e;
    e.wr = 1'b1; e.addr = 32'd0; e.data = {24'd0, d}; e.gid = g;
    apbQ.push_back(e);
  endtask

  task automatic pushRd(input logic [7:0] d);
    apbExp_t e;
    e.wr = 1'b0; e.addr = 32'd1; e.data = 32'd0; e.gid = 1'b0;
    apbQ.push_back(e);
    rxQ.push_back(d);
  endtask

  // Monitor: pops expectations whenever dutA presents an APB access or RX byte.
  always @(negedge pClk) begin : monitor
    apbExp_t e;
    logic [7:0] r;
    if (!pReset) begin
      if (pSel && pEnable) begin
        if (apbQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_access: got addr 0x%0h write %0d, want no access", pAddr, pWrite);
        end else begin
          e = apbQ.pop_front();
          chk("apb_write", {31'd0, pWrite}, {31'd0, e.wr});
          chk("apb_addr", pAddr, e.addr);
          if (e.wr) begin
            chk("apb_wdata", pWdata, e.data);
            chk("grant_id", {31'd0, grant_id}, {31'd0, e.gid});
          end
        end
      end
      if (rx_data_valid) begin
        rxPulses++;
        if (rxQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_rx: got rx_data 0x%0h, want no pulse", rx_data);
        end else begin
          r = rxQ.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, r});
        end
      end
      if (req0_ready && req1_ready) begin
        totalCnt++;
        $display("FAIL ready_both: got req0_ready=1 req1_ready=1, want at most one");
      end
      if (tx_timeout) aTimeouts++;
    end
  end

  task automatic waitReady(input bit useT, output bit who);
    bit found;
    logic r0, r1;
    found = 1'b0;
    who = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pClk);
      r0 = useT ? tReq0Ready : req0_ready;
      r1 = useT ? tReq1Ready : req1_ready;
      if (r0 || r1) begin
        found = 1'b1;
        who = r1;
      end
    end
    if (!found) begin
      totalCnt++;
      $display("FAIL ready_wait: got no ready within 200 cycles, want a ready pulse");
    end
  endtask

  task automatic waitAccess(input bit useT);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pClk);
      if (useT ? (tPSel && tPEnable) : (pSel && pEnable)) found = 1'b1;
    end
    if (!found) begin
      totalCnt++;
      $display("FAIL access_wait: got no APB access within 200 cycles, want one");
    end
  endtask

  task automatic serveBusy(input int dly, input int len);
    repeat (dly) @(posedge pClk);
    #1 tx_busy = 1'b1;
    repeat (len) @(posedge pClk);
    #1 tx_busy = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit who;
    bit expG;
    int n;
    logic [7:0] k0, k1;

    pReset = 1'b1; rstT = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'd0; req1_data = 8'd0;
    rx_avail = 1'b0; tx_busy = 1'b0; pReadData = 32'd0;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (3) @(posedge pClk);
    #1 req0_valid = 1'b1;
    @(negedge pClk);
    chk("rst_pSel", {31'd0, pSel}, 32'd0);
    chk("rst_pEnable", {31'd0, pEnable}, 32'd0);
    chk("rst_pWrite", {31'd0, pWrite}, 32'd0);
    chk("rst_pAddr", pAddr, 32'd0);
    chk("rst_pWdata", pWdata, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_timeout", {31'd0, tx_timeout}, 32'd0);
    req0_valid = 1'b0;
    @(posedge pClk);
    #1 pReset = 1'b0;

    // Single write from requester 0, tx_busy from 5 cycles after ACCESS for 100 cycles.
    pushWr(8'h0A, 1'b0);
    req0_data = 8'h0A; req0_valid = 1'b1;
    waitReady(1'b0, who);
    chk("t1_who", {31'd0, who}, 32'd0);
    @(posedge pClk);
    #1 req0_valid = 1'b0;
    waitAccess(1'b0);
    repeat (5) @(posedge pClk);
    #1 tx_busy = 1'b1;
    repeat (100) @(posedge pClk);
    @(negedge pClk);
    chk("t1_state_busy", 32'(dutA.state), 32'(WAIT_DONE));
    @(posedge pClk);
    #1 tx_busy = 1'b0;
    @(negedge pClk);
    chk("t1_state_fall", 32'(dutA.state), 32'(WAIT_DONE));
    @(negedge pClk);
    chk("t1_state_idle", 32'(dutA.state), 32'(IDLE));

    // RX read.
    pReadData = 32'h0000_0014;
    pushRd(8'h14);
    rx_avail = 1'b1;
    waitAccess(1'b0);
    @(posedge pClk);
    #1 rx_avail = 1'b0;
    @(negedge pClk);
    chk("t2_rx_valid", {31'd0, rx_data_valid}, 32'd1);
    @(negedge pClk);
    chk("t2_rx_valid_once", {31'd0, rx_data_valid}, 32'd0);
    chk("t2_state_idle", 32'(dutA.state), 32'(IDLE));

    // RX and requester 1 together: read first, then the write.
    pReadData = 32'hFFFF_FF33;
    pushRd(8'h33);
    pushWr(8'h5C, 1'b1);
    rx_avail = 1'b1; req1_data = 8'h5C; req1_valid = 1'b1;
    waitAccess(1'b0);
    @(posedge pClk);
    #1 rx_avail = 1'b0;
    waitReady(1'b0, who);
    chk("t3_who", {31'd0, who}, 32'd1);
    @(posedge pClk);
    #1 req1_valid = 1'b0;
    waitAccess(1'b0);
    serveBusy(1, 3);

    // Both requesters continuously valid for four grants.
    k0 = 8'hA0; k1 = 8'hB0;
    for (int i = 0; i < 4; i++) begin
`ifdef UART_SCHED_RR_EN
      expG = i[0];
`else
      expG = 1'b0;
`endif
      if (expG) begin pushWr(k1, 1'b1); k1++; end
      else begin pushWr(k0, 1'b0); k0++; end
    end
    req0_data = 8'hA0; req1_data = 8'hB0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef UART_SCHED_RR_EN
      expG = i[0];
`else
      expG = 1'b0;
`endif
      waitReady(1'b0, who);
      chk("t4_grant", {31'd0, who}, {31'd0, expG});
      @(posedge pClk);
      #1;
      if (who) req1_data = req1_data + 8'd1;
      else req0_data = req0_data + 8'd1;
      if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      waitAccess(1'b0);
      serveBusy(1, 2);
    end

    // Timeout on dutT while dutA is held in reset.
    @(posedge pClk);
    #1 pReset = 1'b1;
    @(posedge pClk);
    #1 rstT = 1'b0;
    req0_data = 8'h77; req0_valid = 1'b1;
    @(negedge pClk);
    chk("t5_dutA_ready_rst", {31'd0, req0_ready}, 32'd0);
    waitReady(1'b1, who);
    chk("t5_who", {31'd0, who}, 32'd0);
    @(posedge pClk);
    #1 req0_valid = 1'b0;
    waitAccess(1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pClk);
      n++;
      if (tTxTimeout) break;
    end
    chk("t5_timeout_latency", n, 32'd50);
    @(negedge pClk);
    chk("t5_timeout_pulse", {31'd0, tTxTimeout}, 32'd0);
    chk("t5_state_idle", 32'(dutT.state), 32'(IDLE));
    rstT = 1'b1;
    @(posedge pClk);
    #1 pReset = 1'b0;

    // Reset pulsed during WAIT_DONE, then a fresh request.
    pushWr(8'h3C, 1'b0);
    req0_data = 8'h3C; req0_valid = 1'b1;
    waitReady(1'b0, who);
    @(posedge pClk);
    #1 req0_valid = 1'b0;
    waitAccess(1'b0);
    repeat (2) @(posedge pClk);
    #1 tx_busy = 1'b1;
    repeat (3) @(posedge pClk);
    @(negedge pClk);
    chk("t6_state_wait", 32'(dutA.state), 32'(WAIT_DONE));
    #2 pReset = 1'b1;
    tx_busy = 1'b0;
    req1_data = 8'h9E; req1_valid = 1'b1;
    #1;
    chk("t6_pSel", {31'd0, pSel}, 32'd0);
    chk("t6_pEnable", {31'd0, pEnable}, 32'd0);
    chk("t6_pWrite", {31'd0, pWrite}, 32'd0);
    chk("t6_pWdata", pWdata, 32'd0);
    chk("t6_rx_data", {24'd0, rx_data}, 32'd0);
    chk("t6_grant_id", {31'd0, grant_id}, 32'd0);
    chk("t6_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("t6_state", 32'(dutA.state), 32'(IDLE));
    pushWr(8'h9E, 1'b1);
    @(posedge pClk);
    #1 pReset = 1'b0;
    waitReady(1'b0, who);
    chk("t6_who", {31'd0, who}, 32'd1);
    @(posedge pClk);
    #1 req1_valid = 1'b0;
    waitAccess(1'b0);
    serveBusy(1, 2);
    @(negedge pClk);
    @(negedge pClk);
    chk("t6_state_idle", 32'(dutA.state), 32'(IDLE));

    repeat (3) @(negedge pClk);
    chk("end_apb_queue", apbQ.size(), 32'd0);
    chk("end_rx_queue", rxQ.size(), 32'd0);
    chk("end_rx_pulses", rxPulses, 32'd2);
    chk("end_dutA_timeouts", aTimeouts, 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
